wb_queue: RTL

//  Writeback stage that feeds the register file write port (we/waddr/wdata).
//  - Accepts retiring results from the MEM stage over a valid/ready handshake.
//  - Aligns, sign- or zero-extends load data at enqueue.
//  - Buffers results in a small FIFO so that a downstream write-port stall

---
 rtl/wb_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - writeback queue: load align/extend at enqueue, small FIFO feeding the register write port
module wb_queue #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we,
  input  logic [AW-1:0]          in_waddr,
  input  logic [DW-1:0]          in_wdata,
  input  logic [2:0]             in_ld_type,
  input  logic [1:0]             in_addr_lo,
  input  logic [DW-1:0]          in_mem_rdata,
  input  logic                   wb_stall,
  output logic                   we,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   misalign_err
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LW  = 3'b101;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   cnt;

  logic          mem_we    [DEPTH];
  logic [AW-1:0] mem_waddr [DEPTH];
  logic [DW-1:0] mem_wdata [DEPTH];

  logic          push;
  logic          pop;
  logic          empty;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] enq_data;
  logic          misaligned;
  logic          enq_we;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != (PW+1)'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = ~empty & ~wb_stall & ~flush;
  assign count    = cnt;

  // Load lanes are little-endian; the halfword lane ignores addr_lo[0].
  always_comb begin
    ld_byte    = in_mem_rdata[7:0];
    ld_half    = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    enq_data   = in_wdata;
    misaligned = 1'b0;
    case (in_addr_lo)
      2'd0:    ld_byte = in_mem_rdata[7:0];
      2'd1:    ld_byte = in_mem_rdata[15:8];
      2'd2:    ld_byte = in_mem_rdata[23:16];
      default: ld_byte = in_mem_rdata[31:24];
    endcase
    case (in_ld_type)
      LD_LB:  enq_data = {{(DW-8){ld_byte[7]}}, ld_byte};
      LD_LBU: enq_data = {{(DW-8){1'b0}}, ld_byte};
      LD_LH: begin
        enq_data   = {{(DW-16){ld_half[15]}}, ld_half};
        misaligned = in_addr_lo[0];
      end
      LD_LHU: begin
        enq_data   = {{(DW-16){1'b0}}, ld_half};
        misaligned = in_addr_lo[0];
      end
      LD_LW: begin
        enq_data   = in_mem_rdata;
        misaligned = (in_addr_lo != 2'b00);
      end
      default: enq_data = in_wdata;
    endcase
  end

  // Misaligned loads and writes to r0 still occupy a slot but never write.
  assign enq_we = in_we & ~misaligned & (in_waddr != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr]    <= enq_we;
      mem_waddr[wr_ptr] <= in_waddr;
      mem_wdata[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= push & misaligned;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign we    = pop & mem_we[rd_ptr];
  assign waddr = pop ? mem_waddr[rd_ptr] : '0;
  assign wdata = pop ? mem_wdata[rd_ptr] : '0;

endmodule
